// File: rtl/soc_sim_monitor.sv
// rtl/soc_sim_monitor.sv - GPIO/UART simulation observer with timestamped event FIFO
module soc_sim_monitor #(
    parameter int          GPIO_W       = 8,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          TS_W         = 20,
    parameter int          MAX_CYCLES   = 400000,
    parameter logic [7:0]  END_BYTE     = 8'h04
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPIO_W-1:0] gpio,
    input  logic              uart_line,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic              ev_kind,
    output logic [GPIO_W-1:0] ev_data,
    output logic [TS_W-1:0]   ev_time,
    output logic              overflow,
    output logic              frame_err,
    output logic              eot,
    output logic              timeout
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int EW = 1 + GPIO_W + TS_W;
    localparam logic [TS_W-1:0] MAX_L   = TS_W'(MAX_CYCLES);
    localparam logic [CW-1:0]   HALF_L  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   FULL_L  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]     PTR_ONE = (AW+1)'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_WAITH = 3'd4;

    logic [TS_W-1:0]   cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic [GPIO_W-1:0] g_q, prev_q;
    logic              s1_q, s2_q;
    logic [2:0]        st_q, st_d;
    logic [CW-1:0]     bc_q, bc_d;
    logic [2:0]        bi_q, bi_d;
    logic [7:0]        sh_q, sh_d;
    logic              skid_v_q, skid_v_d;
    logic [GPIO_W-1:0] skid_data_q, skid_data_d;
    logic [TS_W-1:0]   skid_time_q, skid_time_d;
    logic [AW:0]       wr_q, rd_q;
    logic              overflow_q, frame_err_q, frame_err_d, eot_q, eot_d;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];

    logic              gpio_push, uart_push, skid_drop;
    logic              push_req, push_ok, push_drop, pop, full, empty;
    logic              push_kind;
    logic [GPIO_W-1:0] push_data, u_ext;
    logic [TS_W-1:0]   push_time;
    logic [EW-1:0]     head;

    always_comb begin
        cnt_d     = (cnt_q == MAX_L) ? cnt_q : cnt_q + TS_W'(1);
        timeout_d = timeout_q | (cnt_d == MAX_L);
        gpio_push = (g_q != prev_q);
        u_ext      = '0;
        u_ext[7:0] = sh_q;
    end

    // UART receiver: half-bit wait to the start-bit centre, then one sample per bit period
    always_comb begin
        st_d        = st_q;
        bc_d        = bc_q;
        bi_d        = bi_q;
        sh_d        = sh_q;
        uart_push   = 1'b0;
        frame_err_d = frame_err_q;
        eot_d       = eot_q;
        case (st_q)
            S_IDLE: if (!s2_q) begin
                st_d = S_START;
                bc_d = HALF_L;
            end
            S_START: if (bc_q != '0) bc_d = bc_q - CW'(1);
                     else if (!s2_q) begin
                         st_d = S_DATA;
                         bc_d = FULL_L;
                         bi_d = 3'd0;
                     end else st_d = S_IDLE;
            S_DATA: if (bc_q != '0) bc_d = bc_q - CW'(1);
                    else begin
                        sh_d = {s2_q, sh_q[7:1]};
                        bc_d = FULL_L;
                        bi_d = bi_q + 3'd1;
                        if (bi_q == 3'd7) st_d = S_STOP;
                    end
            S_STOP: if (bc_q != '0) bc_d = bc_q - CW'(1);
                    else if (s2_q) begin
                        uart_push = 1'b1;
                        eot_d     = eot_q | (sh_q == END_BYTE);
                        st_d      = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        st_d        = S_WAITH;
                    end
            S_WAITH: if (s2_q) st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    // GPIO wins the FIFO port; a colliding UART byte waits one cycle in the skid slot
    always_comb begin
        push_kind   = 1'b0;
        push_data   = g_q;
        push_time   = cnt_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_time_d = skid_time_q;
        skid_drop   = 1'b0;
        if (gpio_push) begin
            if (uart_push) begin
                if (skid_v_q) skid_drop = 1'b1;
                else begin
                    skid_v_d    = 1'b1;
                    skid_data_d = u_ext;
                    skid_time_d = cnt_q;
                end
            end
        end else if (skid_v_q) begin
            push_kind = 1'b1;
            push_data = skid_data_q;
            push_time = skid_time_q;
            if (uart_push) begin
                skid_data_d = u_ext;
                skid_time_d = cnt_q;
            end else skid_v_d = 1'b0;
        end else if (uart_push) begin
            push_kind = 1'b1;
            push_data = u_ext;
        end
    end

    assign push_req  = gpio_push | skid_v_q | uart_push;
    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop       = ev_valid && ev_ready;
    assign push_ok   = push_req && (!full || pop);
    assign push_drop = push_req && full && !pop;
    assign head      = mem_q[rd_q[AW-1:0]];

    assign ev_valid  = !empty;
    assign ev_kind   = ev_valid ? head[EW-1] : 1'b0;
    assign ev_data   = ev_valid ? head[EW-2 -: GPIO_W] : '0;
    assign ev_time   = ev_valid ? head[TS_W-1:0] : '0;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
    assign eot       = eot_q;
    assign timeout   = timeout_q;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= {push_kind, push_data, push_time};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            g_q         <= '0;
            prev_q      <= '0;
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            st_q        <= S_IDLE;
            bc_q        <= '0;
            bi_q        <= '0;
            sh_q        <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_time_q <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            eot_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            g_q         <= gpio;
            prev_q      <= g_q;
            s1_q        <= uart_line;
            s2_q        <= s1_q;
            st_q        <= st_d;
            bc_q        <= bc_d;
            bi_q        <= bi_d;
            sh_q        <= sh_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_time_q <= skid_time_d;
            if (push_ok) wr_q <= wr_q + PTR_ONE;
            if (pop)     rd_q <= rd_q + PTR_ONE;
            overflow_q  <= overflow_q | push_drop | skid_drop;
            frame_err_q <= frame_err_d;
            eot_q       <= eot_d;
        end
    end
endmodule

// File: tb/tb_soc_sim_monitor.sv
// tb/tb_soc_sim_monitor.sv - scoreboard bench for soc_sim_monitor
module tb_soc_sim_monitor;
    localparam int TW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    gpio, wd_gpio;
    logic          uart_line, ev_ready;
    logic          ev_valid, ev_kind, overflow, frame_err, eot, timeout;
    logic [7:0]    ev_data;
    logic [TW-1:0] ev_time;
    logic          wd_uart, wd_ready;
    logic          wd_valid, wd_kind, wd_overflow, wd_frame_err, wd_eot, wd_timeout;
    logic [7:0]    wd_data;
    logic [TW-1:0] wd_time;

    typedef struct packed {
        logic          kind;
        logic [7:0]    data;
        logic [TW-1:0] ts;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  n_total = 0;
    int  n_bad   = 0;
    int  n_pop   = 0;
    int  cyc;

    soc_sim_monitor u_dut (
        .clk(clk), .rst(rst), .gpio(gpio), .uart_line(uart_line),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_kind(ev_kind),
        .ev_data(ev_data), .ev_time(ev_time), .overflow(overflow),
        .frame_err(frame_err), .eot(eot), .timeout(timeout)
    );

    soc_sim_monitor #(.MAX_CYCLES(100)) u_wd (
        .clk(clk), .rst(rst), .gpio(wd_gpio), .uart_line(wd_uart),
        .ev_valid(wd_valid), .ev_ready(wd_ready), .ev_kind(wd_kind),
        .ev_data(wd_data), .ev_time(wd_time), .overflow(wd_overflow),
        .frame_err(wd_frame_err), .eot(wd_eot), .timeout(wd_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic k, input logic [7:0] d, input int t);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.ts   = TW'(t);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst && ev_valid && ev_ready) begin
            check("ev_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("ev_kind", 32'(ev_kind), 32'(mon_e.kind));
                check("ev_data", 32'(ev_data), 32'(mon_e.data));
                check("ev_time", 32'(ev_time), 32'(mon_e.ts));
                n_pop++;
            end
        end
    end

    // Frame starts right after edge c; stop-bit sample lands on edge c+155, stamped c+154
    task automatic send_byte(input logic [7:0] b, input logic stop_ok,
                             input logic collide, input logic [7:0] gv);
        int         c;
        logic [9:0] fr;
        c  = cyc;
        fr = {stop_ok, b, 1'b0};
        if (collide) expect_ev(1'b0, gv, c + 154);
        if (stop_ok) expect_ev(1'b1, b, c + 154);
        for (int n = 0; n < 160; n++) begin
            uart_line = fr[n / 16];
            if (collide && n == 153) gpio = gv;
            tick;
        end
        uart_line = 1'b1;
        repeat (20) tick;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(ev_valid), 0);
        check({tag, "_kind"},  32'(ev_kind), 0);
        check({tag, "_data"},  32'(ev_data), 0);
        check({tag, "_time"},  32'(ev_time), 0);
        check({tag, "_ovf"},   32'(overflow), 0);
        check({tag, "_ferr"},  32'(frame_err), 0);
        check({tag, "_eot"},   32'(eot), 0);
        check({tag, "_tmo"},   32'(timeout), 0);
    endtask

    initial begin
        int p0;
        rst = 1'b0; gpio = 8'h00; wd_gpio = 8'h00; uart_line = 1'b1; ev_ready = 1'b1;
        wd_uart = 1'b1; wd_ready = 1'b1;
        repeat (3) tick;
        check_reset_outputs("rst0");
        rst = 1'b1;

        while (cyc < 10) tick;
        expect_ev(1'b0, 8'h5A, 11);
        gpio = 8'h5A;
        tick; tick;
        check("gpio_valid_hi", 32'(ev_valid), 1);
        tick;
        check("gpio_valid_lo", 32'(ev_valid), 0);

        while (cyc < 99) tick;
        check("wd_before", 32'(wd_timeout), 0);
        tick;
        check("wd_at_max", 32'(wd_timeout), 1);
        repeat (20) tick;
        wd_gpio = 8'h01;
        tick; tick;
        check("wd_ev_valid", 32'(wd_valid), 1);
        check("wd_ev_time_held", 32'(wd_time), 100);
        check("wd_ev_data", 32'(wd_data), 1);
        check("main_no_tmo", 32'(timeout), 0);

        send_byte(8'h41, 1'b1, 1'b0, 8'h00);
        check("ferr_after_41", 32'(frame_err), 0);
        check("eot_after_41", 32'(eot), 0);
        send_byte(8'h04, 1'b1, 1'b0, 8'h00);
        check("eot_after_04", 32'(eot), 1);
        send_byte(8'h55, 1'b0, 1'b0, 8'h00);
        check("ferr_after_55", 32'(frame_err), 1);
        send_byte(8'h33, 1'b1, 1'b0, 8'h00);
        check("sb_empty_uart", 32'(sb.size()), 0);

        send_byte(8'hA5, 1'b1, 1'b1, 8'hC3);
        check("sb_empty_coll", 32'(sb.size()), 0);
        check("ovf_before", 32'(overflow), 0);

        ev_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            gpio = 8'h80 + 8'(i);
            if (i < 16) expect_ev(1'b0, 8'h80 + 8'(i), cyc + 1);
            tick;
        end
        repeat (3) tick;
        check("ovf_set", 32'(overflow), 1);
        check("ovf_valid", 32'(ev_valid), 1);
        p0 = n_pop;
        ev_ready = 1'b1;
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick;
        repeat (3) tick;
        check("drain_count", 32'(n_pop - p0), 16);
        check("drain_empty", 32'(ev_valid), 0);

        uart_line = 1'b0;
        repeat (40) tick;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        sb.delete();
        uart_line = 1'b1;
        repeat (3) tick;
        expect_ev(1'b0, gpio, 1);
        rst = 1'b1;
        repeat (5) tick;
        send_byte(8'h7E, 1'b1, 1'b0, 8'h00);
        check("sb_empty_final", 32'(sb.size()), 0);
        check("ferr_final", 32'(frame_err), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
